// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch sequencer. It owns the program counter and arbitrates the
// single instruction-memory port between the fetch path and an external
// loader. After a taken branch/jump it inserts a fixed number of bubble cycles
// while younger in-flight instructions are killed.
//
// FSM: IDLE (one cycle after reset) -> RUN <-> FLUSH, RUN/FLUSH -> LOAD -> RUN.
//
// Parameters
//   RESET_PC      restart word address after reset and after loader release
//   FLUSH_CYCLES  bubble cycles inserted after a redirect (legal range 1..7)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   stall        in   hazard hold request from the pipeline
//   redirect     in   taken branch/jump strobe (one cycle)
//   redirect_pc  in   [31:0] branch/jump target word address
//   ldr_req      in   loader requests the memory port (level-held)
//   ldr_gnt      out  loader currently owns the memory port
//   pc           out  [31:0] current fetch word address (registered)
//   pc_nxt       out  [31:0] pc + 1, wraps modulo 2^32
//   imem_addr    out  [9:0] fetch address into the 1024-word memory
//   imem_sel     out  memory port owner: 0 fetch, 1 loader
//   fetch_valid  out  instruction fetched this cycle is valid for decode
//   flush        out  kill younger in-flight instructions
//   state        out  [1:0] 00 IDLE, 01 RUN, 10 FLUSH, 11 LOAD
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ldr_req,
  output logic        ldr_gnt,
  output logic [31:0] pc,
  output logic [31:0] pc_nxt,
  output logic [9:0]  imem_addr,
  output logic        imem_sel,
  output logic        fetch_valid,
  output logic        flush,
  output logic [1:0]  state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  // The counter is loaded with one less than the bubble count because the
  // cycle in which it reads zero is itself the last bubble.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [2:0]  cnt_q,   cnt_d;

  assign pc_nxt    = pc_q + 32'd1;
  assign pc        = pc_q;
  assign imem_addr = pc_q[9:0];
  assign state     = state_q;

  // The loader port is released combinationally as soon as ldr_req drops, so
  // the loader sees the grant fall in the very cycle it lets go.
  assign imem_sel  = (state_q == S_LOAD);
  assign ldr_gnt   = (state_q == S_LOAD) && ldr_req;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path through
    // the case statement leaves it unassigned and infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    fetch_valid = 1'b0;
    flush       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = ldr_req ? S_LOAD : S_RUN;
      end

      S_RUN: begin
        // Redirect outranks both the loader and a stall.
        if (redirect) begin
          pc_d    = redirect_pc;
          flush   = 1'b1;
          cnt_d   = FLUSH_INIT;
          state_d = S_FLUSH;
        end else if (ldr_req) begin
          state_d = S_LOAD;
        end else if (!stall) begin
          pc_d        = pc_nxt;
          fetch_valid = 1'b1;
        end
      end

      S_FLUSH: begin
        if (redirect) begin
          // A second redirect during the bubble restarts the bubble window.
          pc_d    = redirect_pc;
          flush   = 1'b1;
          cnt_d   = FLUSH_INIT;
        end else begin
          if (!stall) begin
            pc_d = pc_nxt;
          end
          // The counter runs down regardless of stall: bubbles are counted
          // in cycles, not in fetched addresses.
          if (cnt_q == 3'd0) begin
            state_d = ldr_req ? S_LOAD : S_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      S_LOAD: begin
        // redirect and stall have no effect while the loader owns memory.
        if (!ldr_req) begin
          pc_d    = RESET_PC;
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl with default parameters (RESET_PC = 0,
// FLUSH_CYCLES = 2). Inputs change 1 time unit after a rising edge and
// outputs are compared shortly after that, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ldr_req;
  logic        ldr_gnt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [9:0]  imem_addr;
  logic        imem_sel;
  logic        fetch_valid;
  logic        flush;
  logic [1:0]  state;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;
  localparam logic [1:0] LOAD  = 2'b11;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ldr_req     (ldr_req),
    .ldr_gnt     (ldr_gnt),
    .pc          (pc),
    .pc_nxt      (pc_nxt),
    .imem_addr   (imem_addr),
    .imem_sel    (imem_sel),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full check of the reset-value output set.
  task automatic check_reset(input string tag);
    check({tag, ".state"},   32'(state),       32'(IDLE));
    check({tag, ".pc"},      pc,               32'h0);
    check({tag, ".fv"},      32'(fetch_valid), 32'h0);
    check({tag, ".flush"},   32'(flush),       32'h0);
    check({tag, ".gnt"},     32'(ldr_gnt),     32'h0);
    check({tag, ".sel"},     32'(imem_sel),    32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ldr_req = 1'b0;
    #12;
    check_reset("por");
    check("por.pc_nxt", pc_nxt, 32'h1);
    check("por.addr",   32'(imem_addr), 32'h0);

    // Reset release: IDLE for one cycle, then RUN counting 0,1,2,3.
    tick(); rst = 1'b0; #1;
    check("rel.c0.state", 32'(state), 32'(IDLE));
    check("rel.c0.pc",    pc, 32'd0);
    check("rel.c0.fv",    32'(fetch_valid), 32'h0);
    tick();
    check("rel.c1.state", 32'(state), 32'(RUN));
    check("rel.c1.pc",    pc, 32'd0);
    check("rel.c1.fv",    32'(fetch_valid), 32'h1);
    tick();
    check("rel.c2.pc",    pc, 32'd1);
    tick();
    check("rel.c3.pc",    pc, 32'd2);
    tick();
    check("rel.c4.pc",    pc, 32'd3);
    check("rel.c4.fv",    32'(fetch_valid), 32'h1);
    tick(); tick();
    check("run.pc5",      pc, 32'd5);

    // Redirect at pc=5 to 40: flush same cycle, two bubbles at 40 and 41.
    redirect = 1'b1; redirect_pc = 32'd40; #1;
    check("br40.flush",   32'(flush), 32'h1);
    check("br40.fv",      32'(fetch_valid), 32'h0);
    tick(); redirect = 1'b0; #1;
    check("br40.b0.state", 32'(state), 32'(FLUSH));
    check("br40.b0.pc",    pc, 32'd40);
    check("br40.b0.fv",    32'(fetch_valid), 32'h0);
    check("br40.b0.flush", 32'(flush), 32'h0);
    tick();
    check("br40.b1.pc",    pc, 32'd41);
    check("br40.b1.fv",    32'(fetch_valid), 32'h0);
    tick();
    check("br40.run.state", 32'(state), 32'(RUN));
    check("br40.run.pc",    pc, 32'd42);
    check("br40.run.fv",    32'(fetch_valid), 32'h1);

    // Plain stall in RUN holds pc.
    stall = 1'b1; #1;
    check("stall.fv", 32'(fetch_valid), 32'h0);
    tick(); stall = 1'b0; #1;
    check("stall.pc", pc, 32'd42);

    // Steer to pc=7: redirect to 5, bubbles 5,6, RUN at 7.
    redirect = 1'b1; redirect_pc = 32'd5;
    tick(); redirect = 1'b0;
    tick(); tick(); #1;
    check("to7.state", 32'(state), 32'(RUN));
    check("to7.pc",    pc, 32'd7);

    // Stall and redirect together: redirect wins.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd100; #1;
    check("prio.flush", 32'(flush), 32'h1);
    tick(); redirect = 1'b0; #1;
    check("prio.pc",    pc, 32'd100);
    check("prio.state", 32'(state), 32'(FLUSH));
    // Stall in FLUSH holds pc but the bubble counter still expires.
    tick(); stall = 1'b0; #1;
    check("fstall.pc",    pc, 32'd100);
    check("fstall.state", 32'(state), 32'(FLUSH));
    tick();
    check("fstall.exit.state", 32'(state), 32'(RUN));
    check("fstall.exit.pc",    pc, 32'd101);

    // Steer to pc=9, then a loader session.
    redirect = 1'b1; redirect_pc = 32'd7;
    tick(); redirect = 1'b0;
    tick(); tick(); #1;
    check("to9.pc", pc, 32'd9);
    ldr_req = 1'b1; #1;
    check("ldr.req.fv",  32'(fetch_valid), 32'h0);
    check("ldr.req.gnt", 32'(ldr_gnt), 32'h0);
    tick();
    check("ldr.state", 32'(state), 32'(LOAD));
    check("ldr.gnt",   32'(ldr_gnt), 32'h1);
    check("ldr.sel",   32'(imem_sel), 32'h1);
    check("ldr.pc",    pc, 32'd9);
    // Redirect is ignored while loading.
    redirect = 1'b1; redirect_pc = 32'd200; stall = 1'b1; #1;
    check("ldr.noflush", 32'(flush), 32'h0);
    tick(); redirect = 1'b0; stall = 1'b0; #1;
    check("ldr.hold.pc",    pc, 32'd9);
    check("ldr.hold.state", 32'(state), 32'(LOAD));
    tick(); tick();
    ldr_req = 1'b0; #1;
    check("ldr.rel.gnt",   32'(ldr_gnt), 32'h0);
    check("ldr.rel.state", 32'(state), 32'(LOAD));
    tick();
    check("ldr.done.state", 32'(state), 32'(RUN));
    check("ldr.done.pc",    pc, 32'h0);
    check("ldr.done.sel",   32'(imem_sel), 32'h0);
    check("ldr.done.fv",    32'(fetch_valid), 32'h1);

    // Asynchronous reset in the middle of FLUSH (counter = 1).
    redirect = 1'b1; redirect_pc = 32'd50;
    tick(); redirect = 1'b0; #1;
    check("mf.state", 32'(state), 32'(FLUSH));
    check("mf.pc",    pc, 32'd50);
    #1 rst = 1'b1; #1;
    check_reset("rst.mid_flush");
    tick(); rst = 1'b0;
    tick(); tick(); #1;
    check("rf.pc", pc, 32'd1);

    // Asynchronous reset in the middle of LOAD; ldr_req held through release
    // so IDLE hands straight over to LOAD.
    ldr_req = 1'b1;
    tick();
    check("ml.state", 32'(state), 32'(LOAD));
    #1 rst = 1'b1; #1;
    check_reset("rst.mid_load");
    tick(); rst = 1'b0; #1;
    check("rl.idle", 32'(state), 32'(IDLE));
    tick();
    check("rl.load", 32'(state), 32'(LOAD));
    ldr_req = 1'b0;
    tick();
    check("rl.run",  32'(state), 32'(RUN));

    // Wrap: land on 0xFFFF_FFFF in RUN, then increment to 0.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    tick(); redirect = 1'b0;
    tick(); tick(); #1;
    check("wrap.pre.pc",   pc, 32'hFFFF_FFFF);
    check("wrap.pre.nxt",  pc_nxt, 32'h0);
    check("wrap.pre.addr", 32'(imem_addr), 32'h3FF);
    tick();
    check("wrap.pc",   pc, 32'h0);
    check("wrap.addr", 32'(imem_addr), 32'h0);
    check("wrap.nxt",  pc_nxt, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
